nmr_qsw_pulse_seq: RTL and testbench
====================================

// Module: nmr_qsw_pulse_seq
//
// PURPOSE
//  Q-switch damping pulse sequencer. Sits directly downstream of the Q-switch
//  enable window generator and consumes its EN_QSW output. While EN_QSW is
//  high, every falling edge of ACQ_WND (end of one echo acquisition) launches
//  one Q-switch drive pulse with programmable delay, width and holdoff.
//  QSW_ON drives the Q-switch gate driver.
//
// PARAMETERS
//  DLY_W   8   width of DELAY_CNT (cycles from trigger to pulse start)
//  WID_W   8   width of WIDTH_CNT (pulse high time, cycles)
//  HLD_W   8   width of HOLDOFF_CNT (dead time after pulse, cycles)
//  CNT_W   16  width of QSW_PULSE_COUNT (only with QSW_PULSE_COUNT_EN)
//
// PORTS
//  ADC_CLK          in   1      clock
//  RESET            in   1      reset, asynchronous, active-high
//  EN_QSW           in   1      enable window, ADC_CLK domain
//  ACQ_WND          in   1      acquisition window, asynchronous to ADC_CLK
//  DELAY_CNT        in   DLY_W  delay, quasi-static, latched at trigger
//  WIDTH_CNT        in   WID_W  pulse width, latched at trigger
//  HOLDOFF_CNT      in   HLD_W  holdoff, latched at trigger
//  QSW_ON           out  1      Q-switch drive, registered
//  BUSY             out  1      high in DELAY, PULSE, HOLDOFF
//  ERR_OVERRUN      out  1      sticky: trigger arrived while BUSY
//  QSW_PULSE_COUNT  out  CNT_W  pulses issued (only with QSW_PULSE_COUNT_EN)
//
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, sync flops 1 (no false edge after reset).
//    Async reset mid-pulse forces QSW_ON low immediately.
//  - ACQ_WND passes through a 2-flop synchroniser plus a 3rd flop for edge
//    detect. trig = sync2 & ~sync1... fall = s3 & ~s2; trigger = fall & EN_QSW.
//  - Latency: cycle k is the first edge that samples ACQ_WND low. Trigger is
//    seen at edge k+2. QSW_ON rises at edge k+3+DELAY_CNT and stays high
//    exactly WIDTH_CNT cycles.
//  - FSM IDLE->DELAY->PULSE->HOLDOFF->IDLE, one-hot, all counters count down:
//    IDLE:    on trigger, latch the 3 counts. Go to DELAY, or to PULSE if
//             DELAY_CNT==0.
//    DELAY:   dec; at 0 go to PULSE. EN_QSW low here aborts to IDLE, no pulse.
//    PULSE:   QSW_ON=1, dec; at 0 go to HOLDOFF. Always completes (EN_QSW
//             ignored). WIDTH_CNT==0: skip PULSE, QSW_ON never asserts, no
//             count.
//    HOLDOFF: QSW_ON=0, dec; at 0 go to IDLE (HOLDOFF_CNT==0: IDLE next cycle).
//  - Trigger while BUSY: ignored, ERR_OVERRUN<=1. Cleared by RESET or by a
//    rising edge of EN_QSW. If the rising edge and an overrun occur in the
//    same cycle, the set wins.
//  - Trigger in the same cycle the FSM returns to IDLE counts as an overrun.
//    There is no back-to-back acceptance.
//
// CONFIGURATION
//  QSW_PULSE_COUNT_EN defined: QSW_PULSE_COUNT increments by 1 on each
//   PULSE entry and wraps from 2^CNT_W-1 to 0. It clears on reset and on an
//   EN_QSW rising edge.
//  Not defined: the port and counter are absent. All other behaviour is
//   identical.
//
// TESTING
//  1) EN_QSW=1, D=4, W=3, H=2, ACQ_WND 1->0 sampled at edge k -> QSW_ON high
//     from edge k+7 through k+9. BUSY low at k+12.
//  2) D=0, W=1 -> single-cycle QSW_ON at edge k+3. Count 0->1 (macro on).
//  3) EN_QSW=0 during the fall -> no pulse, BUSY stays 0. EN_QSW dropped in
//     DELAY -> abort, no pulse. Dropped in PULSE -> full W pulse.
//  4) Second ACQ_WND fall during PULSE -> ERR_OVERRUN=1, only 1 pulse.
//     EN_QSW 0->1 -> ERR_OVERRUN=0.
//  5) RESET asserted mid-PULSE -> QSW_ON=0 asynchronously. After release, no
//     pulse until a new fall.
//  6) Macro on, CNT_W=4, 17 spaced falls -> QSW_PULSE_COUNT reads 1 (wrap).
//     W=0 -> no pulse, count unchanged.

Source files
------------

// File: rtl/nmr_qsw_pulse_seq.sv
// nmr_qsw_pulse_seq
//   Q-switch damping pulse sequencer. While EN_QSW is high, each falling edge
//   of ACQ_WND (end of an echo acquisition) launches one QSW_ON pulse with a
//   programmable delay, width and holdoff. Triggers that arrive while a pulse
//   sequence is in flight are dropped and flagged on the sticky ERR_OVERRUN.
//
//   Build option: define QSW_PULSE_COUNT_EN to add the QSW_PULSE_COUNT port
//   and the wrapping pulse counter behind it.
module nmr_qsw_pulse_seq #(
    parameter int DLY_W = 8,
    parameter int WID_W = 8,
    parameter int HLD_W = 8
`ifdef QSW_PULSE_COUNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             ADC_CLK,
    input  logic             RESET,
    input  logic             EN_QSW,
    input  logic             ACQ_WND,
    input  logic [DLY_W-1:0] DELAY_CNT,
    input  logic [WID_W-1:0] WIDTH_CNT,
    input  logic [HLD_W-1:0] HOLDOFF_CNT,
    output logic             QSW_ON,
    output logic             BUSY,
    output logic             ERR_OVERRUN
`ifdef QSW_PULSE_COUNT_EN
    ,
    output logic [CNT_W-1:0] QSW_PULSE_COUNT
`endif
);

    // One down-counter is shared by DELAY, PULSE and HOLDOFF, so it must hold
    // the widest of the three programmed counts.
    localparam int CW_DW = (DLY_W > WID_W) ? DLY_W : WID_W;
    localparam int CW    = (CW_DW > HLD_W) ? CW_DW : HLD_W;

    typedef enum logic [3:0] {
        S_IDLE    = 4'b0001,
        S_DELAY   = 4'b0010,
        S_PULSE   = 4'b0100,
        S_HOLDOFF = 4'b1000
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [WID_W-1:0] wid_lat;
    logic [HLD_W-1:0] hld_lat;

    logic acq_s1;
    logic acq_s2;
    logic acq_s3;
    logic acq_fall;
    logic trigger;
    logic en_d;
    logic en_rise;
    logic busy;
    logic qsw_on_nxt;

    // ACQ_WND synchroniser (s1, s2) plus edge-detect flop (s3). All three
    // come out of reset high so a high ACQ_WND never looks like a fall.
    // NOTE: RESET sits in the sensitivity list, so it acts without a clock
    // edge; this is what drops QSW_ON immediately in the middle of a pulse.
    always_ff @(posedge ADC_CLK or posedge RESET) begin
        if (RESET) begin
            acq_s1 <= 1'b1;
            acq_s2 <= 1'b1;
            acq_s3 <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let each flop sample the previous
            // stage's old value, which is what makes this a shift chain.
            acq_s1 <= ACQ_WND;
            acq_s2 <= acq_s1;
            acq_s3 <= acq_s2;
        end
    end

    assign acq_fall = acq_s3 & ~acq_s2;
    assign trigger  = acq_fall & EN_QSW;

    // Delayed copy of EN_QSW for the rising-edge detect that clears status.
    always_ff @(posedge ADC_CLK or posedge RESET) begin
        if (RESET) begin
            en_d <= 1'b0;
        end else begin
            en_d <= EN_QSW;
        end
    end

    assign en_rise = EN_QSW & ~en_d;

    // FSM state register and the shared down-counter.
    always_ff @(posedge ADC_CLK or posedge RESET) begin
        if (RESET) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Capture width and holdoff at the trigger; delay goes straight into cnt.
    always_ff @(posedge ADC_CLK or posedge RESET) begin
        if (RESET) begin
            wid_lat <= '0;
            hld_lat <= '0;
        end else if ((state == S_IDLE) && trigger) begin
            wid_lat <= WIDTH_CNT;
            hld_lat <= HOLDOFF_CNT;
        end
    end

    // Next-state and counter-load logic. Each phase is loaded with N-1 so it
    // lasts N cycles; HOLDOFF is loaded with N so it lasts N+1 cycles and
    // always gives at least one idle-going cycle.
    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no
        // latch is inferred.
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            S_IDLE: begin
                if (trigger) begin
                    if (DELAY_CNT != '0) begin
                        state_nxt = S_DELAY;
                        cnt_nxt   = CW'(DELAY_CNT) - CW'(1);
                    end else if (WIDTH_CNT != '0) begin
                        state_nxt = S_PULSE;
                        cnt_nxt   = CW'(WIDTH_CNT) - CW'(1);
                    end else begin
                        state_nxt = S_HOLDOFF;
                        cnt_nxt   = CW'(HOLDOFF_CNT);
                    end
                end
            end
            S_DELAY: begin
                if (!EN_QSW) begin
                    state_nxt = S_IDLE;
                end else if (cnt == '0) begin
                    if (wid_lat != '0) begin
                        state_nxt = S_PULSE;
                        cnt_nxt   = CW'(wid_lat) - CW'(1);
                    end else begin
                        state_nxt = S_HOLDOFF;
                        cnt_nxt   = CW'(hld_lat);
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_PULSE: begin
                if (cnt == '0) begin
                    state_nxt = S_HOLDOFF;
                    cnt_nxt   = CW'(hld_lat);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_HOLDOFF: begin
                if (cnt == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        qsw_on_nxt = 1'b0;
        busy       = 1'b1;
        unique case (state)
            S_IDLE:    busy = 1'b0;
            S_DELAY:   qsw_on_nxt = 1'b0;
            S_PULSE:   qsw_on_nxt = 1'b1;
            S_HOLDOFF: qsw_on_nxt = 1'b0;
            default:   busy = 1'b0;
        endcase
    end

    assign BUSY = busy;

    // Registered Q-switch drive, one cycle behind the PULSE state.
    always_ff @(posedge ADC_CLK or posedge RESET) begin
        if (RESET) begin
            QSW_ON <= 1'b0;
        end else begin
            QSW_ON <= qsw_on_nxt;
        end
    end

    // Sticky overrun flag; a new overrun wins over the EN_QSW clear.
    always_ff @(posedge ADC_CLK or posedge RESET) begin
        if (RESET) begin
            ERR_OVERRUN <= 1'b0;
        end else if (trigger && busy) begin
            ERR_OVERRUN <= 1'b1;
        end else if (en_rise) begin
            ERR_OVERRUN <= 1'b0;
        end
    end

`ifdef QSW_PULSE_COUNT_EN
    logic pulse_entry;

    assign pulse_entry = (state_nxt == S_PULSE) && (state != S_PULSE);

    // Wrapping count of PULSE entries, restarted on each EN_QSW rising edge.
    always_ff @(posedge ADC_CLK or posedge RESET) begin
        if (RESET) begin
            QSW_PULSE_COUNT <= '0;
        end else if (en_rise) begin
            QSW_PULSE_COUNT <= pulse_entry ? CNT_W'(1) : '0;
        end else if (pulse_entry) begin
            QSW_PULSE_COUNT <= QSW_PULSE_COUNT + CNT_W'(1);
        end
    end
`else
    // Pulse counter not built in this configuration.
`endif

endmodule

// File: tb/tb_nmr_qsw_pulse_seq.sv
// tb_nmr_qsw_pulse_seq
//   Directed bench for the Q-switch pulse sequencer. Edge numbering: edge 0
//   is the first ADC_CLK edge that samples ACQ_WND low; outputs are sampled
//   1 ns after each edge. Define QSW_PULSE_COUNT_EN to cover the counter.
module tb_nmr_qsw_pulse_seq;

    logic       ADC_CLK = 1'b0;
    logic       RESET;
    logic       EN_QSW;
    logic       ACQ_WND;
    logic [7:0] DELAY_CNT;
    logic [7:0] WIDTH_CNT;
    logic [7:0] HOLDOFF_CNT;
    logic       QSW_ON;
    logic       BUSY;
    logic       ERR_OVERRUN;
`ifdef QSW_PULSE_COUNT_EN
    logic [3:0] QSW_PULSE_COUNT;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 ADC_CLK = ~ADC_CLK;

    nmr_qsw_pulse_seq #(
        .DLY_W(8),
        .WID_W(8),
        .HLD_W(8)
`ifdef QSW_PULSE_COUNT_EN
        ,
        .CNT_W(4)
`endif
    ) dut (
        .ADC_CLK        (ADC_CLK),
        .RESET          (RESET),
        .EN_QSW         (EN_QSW),
        .ACQ_WND        (ACQ_WND),
        .DELAY_CNT      (DELAY_CNT),
        .WIDTH_CNT      (WIDTH_CNT),
        .HOLDOFF_CNT    (HOLDOFF_CNT),
        .QSW_ON         (QSW_ON),
        .BUSY           (BUSY),
        .ERR_OVERRUN    (ERR_OVERRUN)
`ifdef QSW_PULSE_COUNT_EN
        ,
        .QSW_PULSE_COUNT(QSW_PULSE_COUNT)
`endif
    );

    typedef struct {
        int d;
        int w;
        int h;
        int en;
        int exp_first;
        int exp_high;
        int exp_busy_low;
    } vec_t;

    vec_t vecs[7];

    int first_on;
    int high_cnt;
    int n_rises;
    int busy_low;
    logic prev_on;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ADC_CLK);
        #1;
    endtask

    task automatic record(input int e);
        if (QSW_ON) begin
            high_cnt++;
            if (first_on == 0) first_on = e;
            if (!prev_on) n_rises++;
        end
        prev_on = QSW_ON;
        if (BUSY) busy_low = e + 1;
    endtask

    task automatic clear_counts();
        first_on = 0;
        high_cnt = 0;
        n_rises  = 0;
        busy_low = 0;
        prev_on  = QSW_ON;
    endtask

    // Apply one ACQ_WND fall and watch n_edges edges. drop_at >= 0 lowers
    // EN_QSW just after that edge.
    task automatic run_fall(input int d, input int w, input int h, input int en,
                            input int drop_at, input int n_edges);
        DELAY_CNT   = 8'(d);
        WIDTH_CNT   = 8'(w);
        HOLDOFF_CNT = 8'(h);
        EN_QSW      = en[0];
        ACQ_WND     = 1'b0;
        clear_counts();
        for (int e = 0; e < n_edges; e++) begin
            tick();
            record(e);
            if (e == 3) ACQ_WND = 1'b1;
            if (e == drop_at) EN_QSW = 1'b0;
        end
    endtask

    task automatic toggle_en();
        EN_QSW = 1'b0;
        tick();
        EN_QSW = 1'b1;
        tick();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{d: 4,   w: 3,   h: 2,   en: 1, exp_first: 7,   exp_high: 3,   exp_busy_low: 12};
        vecs[1] = '{d: 0,   w: 1,   h: 0,   en: 1, exp_first: 3,   exp_high: 1,   exp_busy_low: 4};
        vecs[2] = '{d: 0,   w: 0,   h: 0,   en: 1, exp_first: 0,   exp_high: 0,   exp_busy_low: 3};
        vecs[3] = '{d: 2,   w: 5,   h: 3,   en: 1, exp_first: 5,   exp_high: 5,   exp_busy_low: 13};
        vecs[4] = '{d: 4,   w: 3,   h: 2,   en: 0, exp_first: 0,   exp_high: 0,   exp_busy_low: 0};
        vecs[5] = '{d: 255, w: 2,   h: 0,   en: 1, exp_first: 258, exp_high: 2,   exp_busy_low: 260};
        vecs[6] = '{d: 1,   w: 255, h: 255, en: 1, exp_first: 4,   exp_high: 255, exp_busy_low: 514};

        RESET       = 1'b1;
        EN_QSW      = 1'b1;
        ACQ_WND     = 1'b1;
        DELAY_CNT   = '0;
        WIDTH_CNT   = '0;
        HOLDOFF_CNT = '0;
        repeat (3) tick();
        check("reset_qsw_on", 32'(QSW_ON), 0);
        check("reset_busy", 32'(BUSY), 0);
        check("reset_err", 32'(ERR_OVERRUN), 0);
`ifdef QSW_PULSE_COUNT_EN
        check("reset_count", 32'(QSW_PULSE_COUNT), 0);
`endif
        RESET = 1'b0;
        clear_counts();
        for (int e = 0; e < 8; e++) begin
            tick();
            record(e);
        end
        check("post_reset_no_busy", 32'(busy_low), 0);

        // Table-driven single triggers.
        for (int i = 0; i < 7; i++) begin
            run_fall(vecs[i].d, vecs[i].w, vecs[i].h, vecs[i].en, -1, 600);
            check($sformatf("v%0d_first_on", i), 32'(first_on), 32'(vecs[i].exp_first));
            check($sformatf("v%0d_high_cycles", i), 32'(high_cnt), 32'(vecs[i].exp_high));
            check($sformatf("v%0d_rises", i), 32'(n_rises), (vecs[i].exp_high > 0) ? 1 : 0);
            check($sformatf("v%0d_busy_low", i), 32'(busy_low), 32'(vecs[i].exp_busy_low));
            check($sformatf("v%0d_err", i), 32'(ERR_OVERRUN), 0);
        end

        // EN_QSW dropped during DELAY: abort, no pulse.
        run_fall(10, 3, 1, 1, 4, 40);
        check("abort_high_cycles", 32'(high_cnt), 0);
        check("abort_busy_low", 32'(busy_low), 5);
        EN_QSW = 1'b1;
        tick();

        // EN_QSW dropped during PULSE: full-width pulse.
        run_fall(2, 6, 1, 1, 6, 40);
        check("pulse_drop_first_on", 32'(first_on), 5);
        check("pulse_drop_high_cycles", 32'(high_cnt), 6);
        check("pulse_drop_busy_low", 32'(busy_low), 12);
        EN_QSW = 1'b1;
        tick();

        // Second fall while in PULSE: overrun, only one pulse.
        DELAY_CNT = 8'd0; WIDTH_CNT = 8'd10; HOLDOFF_CNT = 8'd2;
        ACQ_WND = 1'b0;
        clear_counts();
        for (int e = 0; e < 40; e++) begin
            tick();
            record(e);
            if (e == 2) ACQ_WND = 1'b1;
            if (e == 5) ACQ_WND = 1'b0;
            if (e == 8) ACQ_WND = 1'b1;
        end
        check("ovr_pulse_rises", 32'(n_rises), 1);
        check("ovr_pulse_high", 32'(high_cnt), 10);
        check("ovr_pulse_err", 32'(ERR_OVERRUN), 1);
        EN_QSW = 1'b0;
        tick();
        check("ovr_err_sticky", 32'(ERR_OVERRUN), 1);
        EN_QSW = 1'b1;
        tick();
        check("ovr_err_cleared", 32'(ERR_OVERRUN), 0);

        // Trigger on the cycle the FSM returns to IDLE: overrun, no 2nd pulse.
        DELAY_CNT = 8'd0; WIDTH_CNT = 8'd1; HOLDOFF_CNT = 8'd0;
        ACQ_WND = 1'b0;
        clear_counts();
        for (int e = 0; e < 30; e++) begin
            tick();
            record(e);
            if (e == 0) ACQ_WND = 1'b1;
            if (e == 1) ACQ_WND = 1'b0;
            if (e == 2) ACQ_WND = 1'b1;
        end
        check("ret_idle_rises", 32'(n_rises), 1);
        check("ret_idle_err", 32'(ERR_OVERRUN), 1);
        toggle_en();
        check("ret_idle_err_cleared", 32'(ERR_OVERRUN), 0);

        // Overrun and EN_QSW rising edge in the same cycle: set wins.
        DELAY_CNT = 8'd0; WIDTH_CNT = 8'd8; HOLDOFF_CNT = 8'd0;
        ACQ_WND = 1'b0;
        clear_counts();
        for (int e = 0; e < 40; e++) begin
            tick();
            record(e);
            if (e == 6) check("set_wins_err", 32'(ERR_OVERRUN), 1);
            if (e == 0) ACQ_WND = 1'b1;
            if (e == 2) EN_QSW = 1'b0;
            if (e == 3) ACQ_WND = 1'b0;
            if (e == 5) EN_QSW = 1'b1;
            if (e == 8) ACQ_WND = 1'b1;
        end
        check("set_wins_high", 32'(high_cnt), 8);
        check("set_wins_rises", 32'(n_rises), 1);
        toggle_en();
        check("set_wins_err_cleared", 32'(ERR_OVERRUN), 0);

        // Asynchronous reset in the middle of a pulse.
        DELAY_CNT = 8'd0; WIDTH_CNT = 8'd20; HOLDOFF_CNT = 8'd0;
        ACQ_WND = 1'b0;
        for (int e = 0; e < 6; e++) begin
            tick();
            if (e == 3) ACQ_WND = 1'b1;
        end
        check("mid_pulse_on", 32'(QSW_ON), 1);
        #2;
        RESET = 1'b1;
        #1;
        check("async_reset_qsw_on", 32'(QSW_ON), 0);
        check("async_reset_busy", 32'(BUSY), 0);
        tick();
        tick();
        RESET = 1'b0;
`ifdef QSW_PULSE_COUNT_EN
        check("async_reset_count", 32'(QSW_PULSE_COUNT), 0);
`endif
        clear_counts();
        for (int e = 0; e < 30; e++) begin
            tick();
            record(e);
        end
        check("after_reset_no_pulse", 32'(high_cnt), 0);
        run_fall(0, 1, 0, 1, -1, 10);
        check("after_reset_new_fall", 32'(first_on), 3);
`ifdef QSW_PULSE_COUNT_EN
        check("count_first_pulse", 32'(QSW_PULSE_COUNT), 1);

        // Counter wrap with a 4-bit counter, then a zero-width trigger.
        toggle_en();
        check("count_cleared", 32'(QSW_PULSE_COUNT), 0);
        for (int i = 0; i < 17; i++) begin
            run_fall(0, 1, 0, 1, -1, 10);
        end
        check("count_wrap", 32'(QSW_PULSE_COUNT), 1);
        run_fall(0, 0, 0, 1, -1, 10);
        check("count_w0_unchanged", 32'(QSW_PULSE_COUNT), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
